// File: rtl/etc_tile_sequencer.sv
// etc_tile_sequencer: job controller streaming K tile pairs through one ETC and reducing the partials.
// Define ETC_SEQ_SAT_EN for unsigned saturating multiply-add reduction across tiles.
`timescale 1ns/1ps
module etc_tile_sequencer #(
  parameter int W = 16,
  parameter int KW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [KW-1:0]   cmd_ktiles,
  input  logic            tile_valid,
  output logic            tile_ready,
  input  logic [16*W-1:0] tile_a,
  input  logic [16*W-1:0] tile_b,
  output logic [1:0]      etc_op,
  output logic [16*W-1:0] etc_a,
  output logic [16*W-1:0] etc_b,
  input  logic [16*W-1:0] etc_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [16*W-1:0] res_data,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [KW-1:0] ktiles, issued;
  logic [1:0] pend;
  logic [16*W-1:0] acc, comb;
  logic issue;
  assign issue = tile_ready & tile_valid;
  assign etc_a = tile_a;
  assign etc_b = tile_b;
  assign cmd_ready = rst_n & ~busy;
  assign res_data = acc;
  for (genvar i = 0; i < 16; i++) begin : g_el
    logic [W-1:0] a, o, sum;
    assign a = acc[i*W +: W];
    assign o = etc_out[i*W +: W];
`ifdef ETC_SEQ_SAT_EN
    logic [W:0] s;
    assign s = {1'b0, a} + {1'b0, o};
    assign sum = s[W] ? {W{1'b1}} : s[W-1:0];
`else
    assign sum = a + o;
`endif
    assign comb[i*W +: W] = etc_op == 2'd0 ? sum : a & o;
  end
  // pend[1] marks the cycle whose etc_out belongs to a tile issued two edges earlier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= 2'b00;
      issued <= '0;
      ktiles <= '0;
      acc <= '0;
      etc_op <= 2'd0;
      busy <= 1'b0;
      tile_ready <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      pend <= {pend[0], issue};
      if (pend[1]) acc <= comb;
      case (state)
        IDLE: if (cmd_valid) begin
          etc_op <= cmd_op;
          ktiles <= cmd_ktiles;
          issued <= '0;
          acc <= cmd_op != 2'd0 ? {16*W{1'b1}} : {16*W{1'b0}};
          busy <= 1'b1;
          tile_ready <= cmd_ktiles != '0;
          res_valid <= cmd_ktiles == '0;
          state <= cmd_ktiles == '0 ? DONE : ISSUE;
        end
        ISSUE: if (issue) begin
          issued <= issued + 1'b1;
          if (issued + 1'b1 == ktiles) begin
            tile_ready <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: if (pend == 2'b00) begin
          res_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_etc_tile_sequencer.sv
// tb_etc_tile_sequencer: directed jobs against a job-level model plus an ETC behavioural stand-in.
`timescale 1ns/1ps
module tb_etc_tile_sequencer;
  localparam int W = 16, KW = 4, N = 16*W;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, tile_valid = 0, tile_ready, res_valid, res_ready = 0, busy;
  logic [1:0] cmd_op = 0, etc_op;
  logic [KW-1:0] cmd_ktiles = 0;
  logic [N-1:0] tile_a = 0, tile_b = 0, etc_a, etc_b, etc_out, res_data;
  int checks = 0, failures = 0, ec = 0, a_ec = 0;

  etc_tile_sequencer #(.W(W), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ktiles(cmd_ktiles), .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_a(tile_a),
    .tile_b(tile_b), .etc_op(etc_op), .etc_a(etc_a), .etc_b(etc_b), .etc_out(etc_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  function automatic logic [N-1:0] fill(input logic [W-1:0] v);
    return {16{v}};
  endfunction

  // 4x4 semiring product: op 0 = sum of products, otherwise AND-reduce of ORs
  function automatic logic [N-1:0] etc_fn(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
    logic [N-1:0] r;
    logic [W-1:0] v, p, x, y;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        v = op == 0 ? '0 : '1;
        for (int k = 0; k < 4; k++) begin
          x = a[(i*4+k)*W +: W];
          y = b[(k*4+j)*W +: W];
          p = x * y;
          v = op == 0 ? v + p : v & (x | y);
        end
        r[(i*4+j)*W +: W] = v;
      end
    return r;
  endfunction

  function automatic logic [N-1:0] red(input logic [N-1:0] x, input logic [N-1:0] y, input logic [1:0] op);
    logic [N-1:0] r;
    logic [W:0] s;
    for (int e = 0; e < 16; e++) begin
      s = {1'b0, x[e*W +: W]} + {1'b0, y[e*W +: W]};
`ifdef ETC_SEQ_SAT_EN
      if (s[W]) s = {1'b0, {W{1'b1}}};
`endif
      r[e*W +: W] = op == 0 ? s[W-1:0] : x[e*W +: W] & y[e*W +: W];
    end
    return r;
  endfunction

  // ETC stand-in: inputs captured at e, op sampled at e+1, result visible for the combine at e+2
  logic [N-1:0] s1a, s1b;
  always @(posedge clk) begin
    s1a <= etc_a;
    s1b <= etc_b;
    etc_out <= etc_fn(s1a, s1b, etc_op);
  end

  // job-level model: what must be visible after each edge
  localparam int INF = 32'h7fffffff;
  bit active = 0;
  int cyc = 0, ready_at = INF, m_k = 0, issued = 0;
  logic [1:0] m_op = 0;
  logic [N-1:0] m_acc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 0; issued = 0; m_k = 0; m_acc = '0; ready_at = INF;
    end else begin
      int c;
      c = cyc;
      cyc = c + 1;
      if (!active) begin
        if (cmd_valid) begin
          active = 1; m_op = cmd_op; m_k = int'(cmd_ktiles); issued = 0;
          m_acc = cmd_op == 0 ? '0 : '1;
          ready_at = m_k == 0 ? cyc : INF;
        end
      end else if (c >= ready_at) begin
        if (res_ready) active = 0;
      end else if (issued < m_k && tile_valid) begin
        m_acc = red(m_acc, etc_fn(tile_a, tile_b, m_op), m_op);
        issued++;
        if (issued == m_k) ready_at = cyc + 3;
      end
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", N'(busy), N'(0));
      chk("rst_res_valid", N'(res_valid), N'(0));
      chk("rst_tile_ready", N'(tile_ready), N'(0));
      chk("rst_res_data", res_data, '0);
    end else begin
      bit rv;
      rv = active && cyc >= ready_at;
      chk("cmd_ready", N'(cmd_ready), N'(!active));
      chk("busy", N'(busy), N'(active));
      chk("tile_ready", N'(tile_ready), N'(active && issued < m_k));
      chk("res_valid", N'(res_valid), N'(rv));
      if (rv) chk("res_data", res_data, m_acc);
      if (active) chk("etc_op", N'(etc_op), N'(m_op));
    end
    chk("etc_a", etc_a, tile_a);
    chk("etc_b", etc_b, tile_b);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] op, input int k);
    cmd_op = op; cmd_ktiles = KW'(k); cmd_valid = 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) step;
    chk("cmd_wait", N'(cmd_ready), N'(1));
    step;
    cmd_valid = 0;
    a_ec = ec;
  endtask

  task automatic send_tile(input logic [N-1:0] a, input logic [N-1:0] b, input int gap);
    tile_a = a; tile_b = b; tile_valid = 1;
    for (int i = 0; i < 20 && !tile_ready; i++) step;
    chk("tile_wait", N'(tile_ready), N'(1));
    step;
    tile_valid = 0;
    repeat (gap) step;
  endtask

  task automatic get_result(input string name, input int lat, input logic [N-1:0] exp, input int hold);
    for (int i = 0; i < 40 && !res_valid; i++) step;
    chk({name, "_valid"}, N'(res_valid), N'(1));
    chk({name, "_latency"}, N'(ec - a_ec), N'(lat));
    chk({name, "_data"}, res_data, exp);
    repeat (hold) begin
      step;
      chk({name, "_hold_data"}, res_data, exp);
      chk({name, "_hold_cmd_ready"}, N'(cmd_ready), N'(0));
    end
    res_ready = 1;
    step;
    res_ready = 0;
    chk({name, "_idle"}, N'(busy), N'(0));
  endtask

  logic [N-1:0] ident, seqv, sat_exp;
  initial begin
    for (int i = 0; i < 16; i++) begin
      ident[i*W +: W] = (i % 5 == 0) ? W'(1) : W'(0);
      seqv[i*W +: W] = W'(i);
    end
`ifdef ETC_SEQ_SAT_EN
    sat_exp = fill(16'hFFFF);
`else
    sat_exp = fill(16'h8000);
`endif
    repeat (3) step;
    rst_n = 1;
    step;
    chk("reset_cmd_ready", N'(cmd_ready), N'(1));
    chk("reset_res_data", res_data, '0);
    chk("reset_busy", N'(busy), N'(0));

    start_job(0, 1);
    send_tile(ident, seqv, 0);
    get_result("ident_k1", 4, seqv, 0);

    start_job(0, 3);
    cmd_valid = 1; cmd_op = 1; cmd_ktiles = 5;
    repeat (3) send_tile(fill(1), fill(2), 0);
    cmd_valid = 0;
    get_result("ones_k3", 6, fill(24), 0);

    start_job(0, 3);
    send_tile(fill(1), fill(2), 2);
    send_tile(fill(1), fill(2), 2);
    send_tile(fill(1), fill(2), 0);
    get_result("ones_k3_stall", 10, fill(24), 0);

    start_job(1, 2);
    send_tile(fill(16'h00F0), fill(16'h0F00), 0);
    send_tile(fill(16'h0030), fill(16'h0000), 0);
    get_result("orand_k2", 5, fill(16'h0030), 0);

    start_job(0, 2);
    send_tile(ident, fill(16'hC000), 0);
    send_tile(ident, fill(16'hC000), 0);
    get_result("sat_k2", 5, sat_exp, 0);

    start_job(0, 0);
    chk("k0_tile_ready", N'(tile_ready), N'(0));
    get_result("k0_op0", 0, fill(16'h0000), 0);
    start_job(3, 0);
    chk("k0b_tile_ready", N'(tile_ready), N'(0));
    get_result("k0_op3", 0, fill(16'hFFFF), 0);

    start_job(0, 3);
    send_tile(fill(1), fill(2), 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", N'(busy), N'(0));
    chk("midrst_res_valid", N'(res_valid), N'(0));
    chk("midrst_res_data", res_data, '0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("midrst_cmd_ready", N'(cmd_ready), N'(1));
    start_job(0, 1);
    send_tile(ident, seqv, 0);
    get_result("after_rst", 4, seqv, 5);

    repeat (3) step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: run did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/etc_tile_sequencer.md
# etc_tile_sequencer

Job controller for the 4x4 extended-tensor-core datapath. Accepts a job (semiring op, K tile count), streams K A/B tile pairs into the ETC unit, and tracks the unit's two-stage latency. Reduces the K partial 4x4 results into one accumulator using the op's reduce function, then returns the result over a valid/ready handshake. Sits between the tile-fetch front end and one ETC instance, and owns that instance's `op` input for the whole job.

## Interface
- `W`, 16: element width; must match the ETC instance.
- `KW`, 4: width of the K tile count.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: job handshake.
- `cmd_op` in 2: 0 = multiply-add; any nonzero value = or-and.
- `cmd_ktiles` in KW: number of tile pairs; 0 is legal.
- `tile_valid` in 1, `tile_ready` out 1: tile-pair handshake.
- `tile_a`, `tile_b` in 16*W: packed tiles; element [r][c] at bits [(r*4+c)*W +: W].
- `etc_op` out 2, `etc_a`/`etc_b` out 16*W: drive the ETC instance's `op`, `inA`, `inB`.
- `etc_out` in 16*W: ETC result, same packing as the tiles.
- `res_valid` out 1, `res_ready` in 1, `res_data` out 16*W: result handshake.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `op` and `ktiles`, and load the accumulator with the identity (0 for op 0, all-ones for op≠0).
  - If `ktiles`=0, go to DONE; otherwise go to ISSUE.
- ISSUE
  - `tile_ready`=1; `etc_a`/`etc_b` are combinational pass-through of `tile_a`/`tile_b`.
  - Each `tile_valid&tile_ready` cycle is an issue: increment the issue counter and shift a 1 into the 2-bit pending pipe. Non-issue cycles shift in 0.
  - After the issue that equals `ktiles`, go to DRAIN.
- DRAIN: no issues; wait until the pending pipe is empty and the last result has been combined, then go to DONE.
- Combine, whenever the pipe's output bit is 1, per element:
  - op 0: acc = acc + `etc_out`, modulo 2^W.
  - op≠0: acc = acc & `etc_out`.
- DONE: `res_valid`=1 and `res_data`=acc, held stable until `res_ready`; then go to IDLE.
- `etc_op` is the latched op. It is held from the accept cycle until DONE exits, because the ETC samples `op` one cycle after its inputs.
- No cross-job overlap: a new command is accepted only in IDLE.

## Timing
- ETC latency is 2: a tile issued at edge e produces an `etc_out` value that is captured and combined at edge e+2.
- Throughput: one tile per cycle with `tile_valid` held high.
- Job latency: accept at edge a, K back-to-back issues at edges a+1..a+K, last combine at a+K+2, `res_valid` high from a+K+3.
- K=0 job: `res_valid` high the cycle after accept.
- `tile_valid` stalls mid-job: no issue, 0 shifted into the pipe, combine still proceeds for in-flight tiles.
- `res_ready` low in DONE: hold indefinitely; `cmd_ready` stays 0.
- `cmd_valid` asserted outside IDLE: ignored; not latched.
- Reset (async, any state): state=IDLE, pending pipe=0, counter=0, acc=0, `etc_op`=0.
  - Outputs during and after reset: `res_valid`=0, `tile_ready`=0, `busy`=0, `res_data`=0, `etc_a`/`etc_b` = tile inputs (pass-through).
  - `cmd_ready`=1 once `rst_n` is high.
  - ETC output values produced by pre-reset issues are discarded.

## Configuration
- `ETC_SEQ_SAT_EN` defined: op-0 cross-tile combine is unsigned saturating, clamping at 2^W−1 per element.
- `ETC_SEQ_SAT_EN` undefined: op-0 combine wraps modulo 2^W.
- Or-and behaviour is identical either way.
- In-tile arithmetic inside the ETC always wraps.

## Test plan
- op 0, K=1, A=identity, B[r][c]=r*4+c, W=16 -> one result with `res_data`[r][c]=r*4+c; `res_valid` rises 4 cycles after accept.
- op 0, K=3, each tile A=all-ones (1), B=all 2 -> every element 3*8=24.
  - Rerun with `tile_valid` deasserted 2 cycles between tiles: same value, latency +4.
- op 1, K=2
  - Tile 1: A=0x00F0, B=0x0F00 everywhere -> ETC gives 0x0FF0.
  - Tile 2: A=0x0030, B=0x0000 -> 0x0030.
  - Result 0x0030 in every element.
- op 0, K=2, each ETC partial 0xC000 per element
  - Without the macro: result 0x8000.
  - With `ETC_SEQ_SAT_EN`: result 0xFFFF.
- K=0, op 0 then op 1 -> result all 0x0000, then all 0xFFFF; `tile_ready` never asserted.
- Mid-job checks
  - `rst_n` pulsed low after 1 of 3 issues: `busy`=0 immediately.
  - The next K=1 job returns only its own tile result.
  - `res_ready` held low 5 cycles: `res_data` stable and `cmd_ready`=0 throughout.
